// File: rtl/team_06_trem_pkg.sv
// Shared definitions for the tremolo controller: FSM states and the
// fixed widths/levels used by the datapath and the LFO.
package team_06_trem_pkg;

  localparam int SAMPLE_W = 8;

  // Peak of the triangle LFO and the gain that leaves a sample unchanged
  // (gain is applied as (sample * gain) >> 7, so 128 is unity).
  localparam logic [7:0] LFO_MAX    = 8'd128;
  localparam logic [7:0] GAIN_UNITY = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    OUT
  } state_e;

endpackage

// File: rtl/team_06_trem_lfo.sv
// Triangle LFO for the tremolo: a prescaler counts accepted samples and,
// every 2^rate_sel accepts, moves lfo_level one step along a 0..128..0
// triangle. Optional phase restart through lfo_sync when
// TEAM06_TREM_SYNC_EN is defined; otherwise lfo_sync is ignored.
module team_06_trem_lfo
  import team_06_trem_pkg::*;
(
  input  logic       clkdiv,
  input  logic       rst,
  input  logic       step_en,
  input  logic       en,
  input  logic [2:0] rate_sel,
  input  logic       lfo_sync,
  output logic [7:0] lfo_level
);

  logic [6:0] presc_q, presc_d;
  logic       dir_up_q, dir_up_d;
  logic [7:0] level_q, level_d;
  logic [7:0] presc_lim;

  // Prescaler terminal count: 2^rate_sel - 1 accepted samples.
  assign presc_lim = (8'd1 << rate_sel) - 8'd1;

`ifndef TEAM06_TREM_SYNC_EN
  // Port is kept for interface compatibility but has no effect here.
  logic unused_lfo_sync;
  assign unused_lfo_sync = lfo_sync;
`endif

  // Next-state logic: bypass clears everything, sync restarts the phase
  // and wins over a coincident step, otherwise step on prescaler wrap.
  always_comb begin
    presc_d  = presc_q;
    dir_up_d = dir_up_q;
    level_d  = level_q;
    if (!en) begin
      presc_d  = 7'd0;
      dir_up_d = 1'b1;
      level_d  = 8'd0;
    end else
`ifdef TEAM06_TREM_SYNC_EN
    if (lfo_sync) begin
      presc_d  = 7'd0;
      dir_up_d = 1'b1;
      level_d  = 8'd0;
    end else
`endif
    if (step_en) begin
      if (presc_q == presc_lim[6:0]) begin
        presc_d = 7'd0;
        // Direction flips on the step that lands on a turnaround value so
        // 128 and 0 are each visited for exactly one step.
        if (dir_up_q) begin
          level_d = level_q + 8'd1;
          if (level_q == LFO_MAX - 8'd1) dir_up_d = 1'b0;
        end else begin
          level_d = level_q - 8'd1;
          if (level_q == 8'd1) dir_up_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 7'd1;
      end
    end
  end

  // LFO state registers.
  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      presc_q  <= 7'd0;
      dir_up_q <= 1'b1;
      level_q  <= 8'd0;
    end else begin
      presc_q  <= presc_d;
      dir_up_q <= dir_up_d;
      level_q  <= level_d;
    end
  end

  assign lfo_level = level_q;

endmodule

// File: rtl/team_06_trem_ctrl.sv
// Tremolo controller: a three-state handshake FSM (IDLE/SCALE/OUT) that
// multiplies each accepted sample by a gain derived from a triangle LFO.
// Optional LFO phase restart: define TEAM06_TREM_SYNC_EN.
module team_06_trem_ctrl
  import team_06_trem_pkg::*;
(
  input  logic                clkdiv,
  input  logic                rst,
  input  logic                en,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                sample_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] sample_out,
  input  logic [2:0]          rate_sel,
  input  logic [1:0]          depth_sel,
  input  logic                lfo_sync,
  output logic [7:0]          lfo_level
);

  state_e              state_q;
  logic                ready_q;
  logic                out_valid_q;
  logic [SAMPLE_W-1:0] sample_out_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic [7:0]          gain_q;

  logic                accept;
  logic [7:0]          lfo_shifted;
  logic [7:0]          gain_d;
  logic [15:0]         product;
  logic [SAMPLE_W-1:0] scaled;

  assign accept = (state_q == IDLE) && ready_q && sample_valid;

  // Deeper settings shift the LFO less; depth 3 uses the full 0..128 swing.
  assign lfo_shifted = lfo_level >> (2'd3 - depth_sel);
  assign gain_d      = en ? (GAIN_UNITY - lfo_shifted) : GAIN_UNITY;

  // Q1.7 gain: product >> 7, clipped to full scale if it ever exceeds 8 bits.
  assign product = {8'd0, sample_q} * {8'd0, gain_q};
  assign scaled  = product[15] ? 8'hFF : product[14:7];

  team_06_trem_lfo u_lfo (
    .clkdiv   (clkdiv),
    .rst      (rst),
    .step_en  (accept),
    .en       (en),
    .rate_sel (rate_sel),
    .lfo_sync (lfo_sync),
    .lfo_level(lfo_level)
  );

  // Handshake FSM with registered outputs; gain is captured at accept so
  // control changes never affect a sample already in flight.
  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
      sample_q     <= '0;
      gain_q       <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sample_q <= sample_in;
            gain_q   <= gain_d;
            ready_q  <= 1'b0;
            state_q  <= SCALE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SCALE: begin
          sample_out_q <= scaled;
          out_valid_q  <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          ready_q     <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign out_valid    = out_valid_q;
  assign sample_out   = sample_out_q;

endmodule

// File: tb/tb_team_06_trem_ctrl.sv
// Directed testbench for team_06_trem_ctrl. The sync scenario follows
// TEAM06_TREM_SYNC_EN: restart when defined, ignored when not.
module tb_team_06_trem_ctrl;

  logic       clkdiv = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sample_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sample_out;
  logic [2:0] rate_sel = 3'd0;
  logic [1:0] depth_sel = 2'd0;
  logic       lfo_sync = 1'b0;
  logic [7:0] lfo_level;

  int errors = 0;
  int checks = 0;

  always #5 clkdiv = ~clkdiv;

  team_06_trem_ctrl dut (
    .clkdiv      (clkdiv),
    .rst         (rst),
    .en          (en),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .sample_ready(sample_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sample_out  (sample_out),
    .rate_sel    (rate_sel),
    .depth_sel   (depth_sel),
    .lfo_sync    (lfo_sync),
    .lfo_level   (lfo_level)
  );

  // Drives one full transaction starting at a negedge in IDLE; returns the
  // output value and whether out_valid showed up within the cycle budget.
  task automatic send(input logic [7:0] d, output logic [7:0] res, output bit ok);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!sample_ready && n < 10) begin
      @(negedge clkdiv);
      n++;
    end
    sample_valid = 1'b1;
    sample_in    = d;
    @(negedge clkdiv);
    sample_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clkdiv);
      n++;
    end
    ok  = out_valid;
    res = sample_out;
    @(negedge clkdiv);
  endtask

  task automatic test_reset();
    @(negedge clkdiv);
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b expected 0", sample_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    checks++; if (sample_out !== 8'd0) begin errors++; $display("FAIL rst_sample_out: got %0d expected 0", sample_out); end
    checks++; if (lfo_level !== 8'd0) begin errors++; $display("FAIL rst_lfo_level: got %0d expected 0", lfo_level); end
    rst = 1'b0;
    @(negedge clkdiv);
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b expected 1", sample_ready); end
    $display("test_reset done");
  endtask

  task automatic test_bypass();
    en = 1'b0;
    out_ready = 1'b1;
    sample_valid = 1'b1;
    sample_in = 8'd200;
    @(negedge clkdiv);
    sample_valid = 1'b0;
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL bypass_ready_scale: got %0b expected 0", sample_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bypass_valid_early: got %0b expected 0", out_valid); end
    @(negedge clkdiv);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid_latency: got %0b expected 1", out_valid); end
    checks++; if (sample_out !== 8'd200) begin errors++; $display("FAIL bypass_data: got %0d expected 200", sample_out); end
    @(negedge clkdiv);
    checks++; if (sample_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bypass_return: got ready=%0b valid=%0b expected ready=1 valid=0", sample_ready, out_valid); end
    $display("test_bypass: sample 200 -> %0d", sample_out);
  endtask

  task automatic test_full_depth();
    logic [7:0] res;
    bit ok;
    int lvl, exp;
    en = 1'b1;
    depth_sel = 2'd3;
    rate_sel = 3'd0;
    for (int k = 0; k <= 256; k++) begin
      lvl = (k <= 128) ? k : 256 - k;
      if (k == 128) begin
        checks++; if (lfo_level !== 8'd128) begin errors++; $display("FAIL full_peak_level: got %0d expected 128", lfo_level); end
      end
      if (k == 256) begin
        checks++; if (lfo_level !== 8'd0) begin errors++; $display("FAIL full_trough_level: got %0d expected 0", lfo_level); end
      end
      exp = (255 * (128 - lvl)) >> 7;
      send(8'd255, res, ok);
      checks++;
      if (!ok || res !== exp[7:0]) begin
        errors++;
        $display("FAIL full_out[%0d]: got %0d (valid=%0b) expected %0d", k, res, ok, exp);
      end
    end
    $display("test_full_depth: last out %0d, lfo_level %0d", res, lfo_level);
  endtask

  task automatic test_backpressure();
    en = 1'b0;
    out_ready = 1'b0;
    sample_valid = 1'b1;
    sample_in = 8'd77;
    @(negedge clkdiv);
    sample_valid = 1'b0;
    @(negedge clkdiv);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || sample_out !== 8'd77 || sample_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%0b data=%0d ready=%0b expected 1/77/0", c, out_valid, sample_out, sample_ready);
      end
      @(negedge clkdiv);
    end
    out_ready = 1'b1;
    @(negedge clkdiv);
    checks++; if (sample_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%0b valid=%0b expected 1/0", sample_ready, out_valid); end
    $display("test_backpressure: held 77 for 5 cycles");
  endtask

  task automatic test_prescaler();
    logic [7:0] res;
    bit ok;
    en = 1'b0;
    @(negedge clkdiv);
    checks++; if (lfo_level !== 8'd0) begin errors++; $display("FAIL en0_clears_level: got %0d expected 0", lfo_level); end
    en = 1'b1;
    rate_sel = 3'd2;
    depth_sel = 2'd1;
    for (int k = 0; k < 8; k++) begin
      send(8'd100, res, ok);
      checks++; if (!ok || res !== 8'd100) begin errors++; $display("FAIL presc_out[%0d]: got %0d expected 100", k, res); end
      if (k == 3) begin
        checks++; if (lfo_level !== 8'd1) begin errors++; $display("FAIL presc_level4: got %0d expected 1", lfo_level); end
      end
    end
    checks++; if (lfo_level !== 8'd2) begin errors++; $display("FAIL presc_level8: got %0d expected 2", lfo_level); end
    depth_sel = 2'd2;
    send(8'd100, res, ok);
    checks++; if (!ok || res !== 8'd99) begin errors++; $display("FAIL depth2_out: got %0d expected 99", res); end
    depth_sel = 2'd3;
    send(8'd100, res, ok);
    checks++; if (!ok || res !== 8'd98) begin errors++; $display("FAIL depth3_out: got %0d expected 98", res); end
    $display("test_prescaler: lfo_level %0d", lfo_level);
  endtask

  task automatic test_reset_mid();
    sample_valid = 1'b1;
    sample_in = 8'd10;
    @(negedge clkdiv);
    sample_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || lfo_level !== 8'd0) begin errors++; $display("FAIL midrst_clear: got valid=%0b level=%0d expected 0/0", out_valid, lfo_level); end
    @(negedge clkdiv);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output: got %0b expected 0", out_valid); end
    rst = 1'b0;
    @(negedge clkdiv);
    checks++; if (sample_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_recover: got ready=%0b valid=%0b expected 1/0", sample_ready, out_valid); end
    $display("test_reset_mid: in-flight sample dropped");
  endtask

  task automatic test_sync();
    logic [7:0] res;
    bit ok;
    en = 1'b1;
    rate_sel = 3'd0;
    depth_sel = 2'd0;
    for (int k = 0; k < 57; k++) send(8'd1, res, ok);
    checks++; if (lfo_level !== 8'd57) begin errors++; $display("FAIL sync_pre_level: got %0d expected 57", lfo_level); end
    lfo_sync = 1'b1;
    @(negedge clkdiv);
    lfo_sync = 1'b0;
`ifdef TEAM06_TREM_SYNC_EN
    checks++; if (lfo_level !== 8'd0) begin errors++; $display("FAIL sync_restart: got %0d expected 0", lfo_level); end
    for (int k = 0; k < 3; k++) send(8'd1, res, ok);
    lfo_sync = 1'b1;
    sample_valid = 1'b1;
    sample_in = 8'd1;
    @(negedge clkdiv);
    lfo_sync = 1'b0;
    sample_valid = 1'b0;
    checks++; if (lfo_level !== 8'd0) begin errors++; $display("FAIL sync_over_step: got %0d expected 0", lfo_level); end
    repeat (2) @(negedge clkdiv);
`else
    checks++; if (lfo_level !== 8'd57) begin errors++; $display("FAIL sync_ignored: got %0d expected 57", lfo_level); end
`endif
    $display("test_sync: lfo_level %0d", lfo_level);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_full_depth();
    test_backpressure();
    test_prescaler();
    test_reset_mid();
    test_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/team_06_trem_ctrl.md
TEAM_06_TREM_CTRL -- requirements
Module: team_06_trem_ctrl

Interface
REQ-001 SHALL have ports: clkdiv  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: en  in  1  tremolo enable; 0 means bypass.
REQ-004 SHALL have ports: sample_valid  in  1  upstream sample offered.
REQ-005 SHALL have ports: sample_in  in  8  unsigned audio sample.
REQ-006 SHALL have ports: sample_ready  out  1  controller can accept a sample.
REQ-007 SHALL have ports: out_valid  out  1  processed sample available.
REQ-008 SHALL have ports: out_ready  in  1  downstream accepts the output.
REQ-009 SHALL have ports: sample_out  out  8  processed sample.
REQ-010 SHALL have ports: rate_sel  in  3  LFO step occurs every 2^rate_sel accepted samples.
REQ-011 SHALL have ports: depth_sel  in  2  modulation depth, 0 shallowest, 3 full.
REQ-012 SHALL have ports: lfo_sync  in  1  LFO phase restart; only functional under TEAM06_TREM_SYNC_EN.
REQ-013 SHALL have ports: lfo_level  out  8  current triangle value, 0..128.

Function
REQ-014 FSM SHALL have states IDLE, SCALE, OUT; sample_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: sample_valid=1 SHALL register sample_in and the current gain, then go to SCALE; otherwise stay in IDLE.
REQ-016 SCALE: SHALL register sample_out = (sample*gain)>>7 using a 16-bit product, saturated to 255, then go to OUT.
REQ-017 OUT: out_valid SHALL be 1; out_ready=1 SHALL return to IDLE; otherwise hold out_valid and sample_out stable.
REQ-018 Latency SHALL be 2 cycles from the accept edge to out_valid=1; throughput SHALL be at most one sample per 3 cycles.
REQ-019 Gain SHALL be 128 - (lfo_level >> (3-depth_sel)) when en=1, and 128 when en=0, so bypass output equals input.
REQ-020 LFO SHALL be a triangle on lfo_level: count up by 1 to 128, then down by 1 to 0, then up again; period 256 steps.
REQ-021 The turnaround points 128 and 0 SHALL each be held for exactly one step; there SHALL be no overshoot or wrap.
REQ-022 LFO prescaler SHALL count accepted samples; when the count reaches 2^rate_sel-1 on an accept, the LFO SHALL step and the prescaler SHALL clear.
REQ-023 A step SHALL take effect for the next accepted sample, not the current one.
REQ-024 When en=0, lfo_level SHALL be forced to 0 with direction up and the prescaler cleared; the FSM handshake SHALL keep running.
REQ-025 rate_sel, depth_sel and en changes SHALL take effect at the next accept; a sample already in flight SHALL keep its registered gain.

Reset
REQ-026 While rst=1: state=IDLE, sample_ready=0 during reset then 1, out_valid=0, sample_out=0, lfo_level=0, direction=up, prescaler=0.
REQ-027 rst asserted mid-transaction SHALL drop the in-flight sample with no output produced.

Configuration
REQ-028 Macro TEAM06_TREM_SYNC_EN defined: lfo_sync=1 on an edge SHALL set lfo_level=0, direction=up and prescaler=0.
REQ-029 If that edge is also an accept, sync SHALL take precedence over the step.
REQ-030 Macro TEAM06_TREM_SYNC_EN undefined: lfo_sync port SHALL remain but be ignored.

Structure
REQ-031 Package team_06_trem_pkg SHALL hold the FSM state enum, LFO_MAX=128, GAIN_UNITY=128 and the sample width constant 8.
REQ-032 Sub-module team_06_trem_lfo SHALL contain the prescaler, direction flag and triangle counter.
REQ-033 team_06_trem_lfo SHALL have inputs step_en (accept), en, rate_sel and lfo_sync, and output lfo_level.

Verification
REQ-034 Bypass: en=0, accept 200 with out_ready=1 -> sample_out=200, out_valid 2 cycles after accept.
REQ-035 Full depth: en=1, depth_sel=3, rate_sel=0, 128 samples of 255 accepted -> lfo_level reaches 128; next sample's gain=0, so out=0.
REQ-036 Then 128 more samples -> lfo_level returns to 0 and the next output is 255.
REQ-037 Backpressure: out_ready=0 for 5 cycles -> out_valid and sample_out held stable, sample_ready=0; release -> IDLE next cycle.
REQ-038 Prescaler: rate_sel=2, depth_sel=1, 8 accepts -> lfo_level=2; gain = 128-(2>>2) = 128, so output is unchanged.
REQ-039 Reset in SCALE: assert rst -> out_valid stays 0 and lfo_level=0.
REQ-040 With TEAM06_TREM_SYNC_EN defined: lfo_sync pulse at lfo_level=57 -> lfo_level=0 next edge.
